// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-transaction I2C master.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W   = 7;
  localparam int unsigned I2C_DATA_W   = 8;
  localparam logic        I2C_RW_WRITE = 1'b0;
  localparam logic        I2C_RW_READ  = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA_W,
    ST_WACK,
    ST_DATA_R,
    ST_RACK,
    ST_STOP_LOW,
    ST_STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_master_ctrl.sv
// Single-transaction I2C master: START, addr+R/W, ACK, one data byte, STOP.
// SCL/SDA timing is paced by the scl_posedge/scl_negedge strobes from div_clk.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned ADDR_W = I2C_ADDR_W,
  parameter int unsigned DATA_W = I2C_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              en_clk,
  input  logic              scl_posedge,
  input  logic              scl_negedge,
  output logic              scl_o,
  output logic              sda_o,
  input  logic              sda_i,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              ack_err
);

  i2c_state_e        state, state_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic [2:0]        bit_cnt, cnt_nxt;
  logic              rw_q, rw_nxt;
  logic              ack_smp, smp_nxt;
  logic              scl_nxt, sda_nxt, en_nxt, done_nxt, err_nxt;
  logic              pos, neg;

  // Strobes only count while the divider is enabled; posedge wins a tie.
  assign pos = en_clk && scl_posedge;
  assign neg = en_clk && scl_negedge && !scl_posedge;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shift   <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      bit_cnt <= 3'd7;
      rw_q    <= I2C_RW_WRITE;
      ack_smp <= 1'b0;
      scl_o   <= 1'b1;
      sda_o   <= 1'b1;
      en_clk  <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      wdata_q <= wdata_nxt;
      rdata   <= rdata_nxt;
      bit_cnt <= cnt_nxt;
      rw_q    <= rw_nxt;
      ack_smp <= smp_nxt;
      scl_o   <= scl_nxt;
      sda_o   <= sda_nxt;
      en_clk  <= en_nxt;
      done    <= done_nxt;
      ack_err <= err_nxt;
    end
  end

  // Next-state and next-output decode driven by the SCL strobes.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    wdata_nxt = wdata_q;
    rdata_nxt = rdata;
    cnt_nxt   = bit_cnt;
    rw_nxt    = rw_q;
    smp_nxt   = ack_smp;
    scl_nxt   = scl_o;
    sda_nxt   = sda_o;
    en_nxt    = en_clk;
    done_nxt  = 1'b0;
    err_nxt   = ack_err;
    unique case (state)
      ST_IDLE: begin
        scl_nxt = 1'b1;
        sda_nxt = 1'b1;
        if (cmd_valid) begin
          shift_nxt = {cmd_addr, cmd_rw};
          wdata_nxt = cmd_wdata;
          rw_nxt    = cmd_rw;
          en_nxt    = 1'b1;
          err_nxt   = 1'b0;
          cnt_nxt   = 3'd7;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        // sda_o low marks that the START condition has already been driven
        if (pos && sda_o) begin
          sda_nxt = 1'b0;
        end else if (neg && !sda_o) begin
          scl_nxt   = 1'b0;
          sda_nxt   = shift[DATA_W-1];
          cnt_nxt   = 3'd7;
          state_nxt = ST_ADDR;
        end
      end
      ST_ADDR, ST_DATA_W: begin
        if (pos) begin
          scl_nxt = 1'b1;
        end else if (neg) begin
          scl_nxt = 1'b0;
          if (bit_cnt == '0) begin
            sda_nxt   = 1'b1;
            state_nxt = (state == ST_ADDR) ? ST_ADDR_ACK : ST_WACK;
          end else begin
            cnt_nxt   = bit_cnt - 3'd1;
            sda_nxt   = shift[DATA_W-2];
            shift_nxt = {shift[DATA_W-2:0], 1'b0};
          end
        end
      end
      ST_ADDR_ACK, ST_WACK: begin
        if (pos) begin
          scl_nxt = 1'b1;
          smp_nxt = sda_i;
        end else if (neg) begin
          scl_nxt = 1'b0;
          if (state == ST_WACK) begin
            err_nxt   = ack_smp;
            state_nxt = ST_STOP_LOW;
          end else if (ack_smp) begin
            err_nxt   = 1'b1;
            state_nxt = ST_STOP_LOW;
          end else if (rw_q == I2C_RW_WRITE) begin
            shift_nxt = wdata_q;
            sda_nxt   = wdata_q[DATA_W-1];
            cnt_nxt   = 3'd7;
            state_nxt = ST_DATA_W;
          end else begin
            sda_nxt   = 1'b1;
            cnt_nxt   = 3'd7;
            state_nxt = ST_DATA_R;
          end
        end
      end
      ST_DATA_R: begin
        if (pos) begin
          scl_nxt   = 1'b1;
          rdata_nxt = {rdata[DATA_W-2:0], sda_i};
        end else if (neg) begin
          scl_nxt = 1'b0;
          if (bit_cnt == '0) begin
            state_nxt = ST_RACK;
          end else begin
            cnt_nxt = bit_cnt - 3'd1;
          end
        end
      end
      ST_RACK: begin
        // SDA stays released: master NACKs the single read byte
        if (pos) begin
          scl_nxt = 1'b1;
        end else if (neg) begin
          scl_nxt   = 1'b0;
          state_nxt = ST_STOP_LOW;
        end
      end
      ST_STOP_LOW: begin
        // SDA is entered released; SCL may only rise once SDA has been pulled low
        if (neg) begin
          scl_nxt = 1'b0;
          sda_nxt = 1'b0;
        end else if (pos && !sda_o) begin
          scl_nxt   = 1'b1;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (neg) begin
          sda_nxt   = 1'b1;
          en_nxt    = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- Single-transaction I2C master controller that sits directly downstream of div_clk.
- Drives div_clk's en_clk input and consumes its one-cycle scl_posedge/scl_negedge strobes to generate the SCL/SDA waveforms.
- Per command it sends START, then a 7-bit address + R/W bit, takes the slave ACK, then writes or reads one data byte, then sends STOP.
- Software/host side uses a valid/ready command handshake plus done/ack_err status.

Parameters:
ADDR_W, 7, slave address width (only 7 is supported)
DATA_W, 8, data byte width (only 8 is supported)

Ports:
clk  input  1  system clock, same clock as div_clk
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
cmd_rw  input  1  0 = write, 1 = read
cmd_addr  input  ADDR_W  slave address
cmd_wdata  input  DATA_W  write byte
en_clk  output  1  enable to div_clk; high from command accept until STOP completes
scl_posedge  input  1  one-cycle strobe from div_clk: raise SCL
scl_negedge  input  1  one-cycle strobe from div_clk: lower SCL
scl_o  output  1  SCL level, 1 = released
sda_o  output  1  SDA drive, 1 = released, 0 = pull low
sda_i  input  1  sampled SDA line
rdata  output  DATA_W  read byte, valid when done pulses after a read
busy  output  1  high while the state is not IDLE
done  output  1  one-cycle pulse at transaction end
ack_err  output  1  valid with done; 1 = address or write-data NACK

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE, en_clk = 0, scl_o = 1, sda_o = 1, busy = 0, done = 0, ack_err = 0, rdata = 0, bit counter = 7.
  - cmd_ready = 1 once rst_n is released.
- Reset mid-transaction: outputs return to their reset values immediately. No STOP is generated.
- All outputs are registered. A strobe seen in cycle N changes scl_o/sda_o in cycle N+1.
- Strobe priority: if scl_posedge and scl_negedge arrive in the same cycle, scl_posedge is acted on and scl_negedge is ignored. A strobe arriving while en_clk = 0 is ignored.
- Command accept:
  - Latch shift = {addr, rw} and wdata; set en_clk = 1; go to START.
  - cmd_ready deasserts the following cycle.
  - cmd_valid is ignored while busy.
- States:
  - IDLE: scl_o = 1, sda_o = 1.
  - START: on the first scl_posedge, sda_o <= 0 with SCL high (START condition). On the next scl_negedge, scl_o <= 0, drive the MSB of shift, go to ADDR.
  - ADDR: each scl_posedge sets scl_o <= 1. Each scl_negedge sets scl_o <= 0, decrements the counter and drives the next bit. After bit 0's negedge, sda_o <= 1 (release) and go to ADDR_ACK.
  - ADDR_ACK: on scl_posedge, scl_o <= 1 and sample sda_i.
    - On scl_negedge: if the sample was 1, set ack_err and go to STOP_LOW.
    - Otherwise: for a write, drive wdata[7] and go to DATA_W.
    - Otherwise: for a read, release SDA and go to DATA_R.
  - DATA_W: shifts like ADDR. After bit 0, release SDA and go to WACK. WACK samples like ADDR_ACK; NACK sets ack_err. Both outcomes go to STOP_LOW.
  - DATA_R: on each scl_posedge, rdata <= {rdata[6:0], sda_i}, MSB first. After 8 bits, go to RACK; the master drives sda_o = 1 (NACK) for one bit, then STOP_LOW.
  - STOP_LOW: on scl_negedge, scl_o <= 0 and sda_o <= 0. On scl_posedge, scl_o <= 1, go to STOP.
  - STOP: on the next scl_negedge strobe, SCL stays high and sda_o <= 1 (STOP condition). Then en_clk <= 0, done pulses for 1 cycle, go to IDLE.
- Bit counter: 3 bits, reloaded to 7 at each byte start, no wrap beyond 0.
- ack_err clears on the next command accept.

Decomposition:
- Package i2c_pkg: state enum i2c_state_e; localparams I2C_ADDR_W = 7, I2C_DATA_W = 8, I2C_RW_WRITE = 0, I2C_RW_READ = 1.
- No sub-module. The shift register and bit counter stay inline.
- div_clk is instantiated beside this block at top level, not inside it.

Test Plan:
1. Reset mid-write (rst_n low during ADDR bit 3) -> next cycle en_clk = 0, scl_o = 1, sda_o = 1, busy = 0, no done pulse.
2. Write addr 0x50, data 0xA5, slave ACKs both -> SDA during SCL-high reads 1010000 0, then A, then 10100101, then A, then STOP; done with ack_err = 0; en_clk low after STOP.
3. Read addr 0x3C, slave drives 0x96 -> address bits 0111100 1; rdata = 0x96 at done; master NACK (sda_o = 1) on the 9th bit; ack_err = 0.
4. Write addr 0x27, slave NACKs the address -> no data bits sent; STOP follows immediately; done with ack_err = 1.
5. Assert cmd_valid again during busy with addr 0x11 -> ignored; after done, a new command is accepted and ack_err clears.
6. Inject scl_posedge and scl_negedge in the same cycle during ADDR -> only the posedge is applied (scl_o = 1); the bit sequence is unchanged.
